// File: rtl/sr_ff_bank.sv
// sr_ff_bank: bank of independent SR flip-flops with per-bit enable,
// elaboration-time S=R=1 resolution and conflict monitoring.
module sr_ff_bank #(
    parameter int               WIDTH         = 8,
    parameter int               CONFLICT_MODE = 0,
    parameter logic [WIDTH-1:0] RESET_VAL     = '0,
    parameter int               CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] en,
    input  logic [WIDTH-1:0] s,
    input  logic [WIDTH-1:0] r,
    input  logic             clr_stat,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar,
    output logic [WIDTH-1:0] conflict,
    output logic             conflict_sticky,
    output logic [CNT_W-1:0] conflict_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_qbar;
    logic [WIDTH-1:0] r_conflict;
    logic             r_sticky;
    logic [CNT_W-1:0] r_cnt;

    logic [WIDTH-1:0] w_conf;
    logic             w_any;
    logic [WIDTH-1:0] w_q_nxt;
    logic             w_sticky_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;

    // Next value of one bit when both set and reset are requested.
    function automatic logic resolve(input logic cur);
        logic res;
        case (CONFLICT_MODE)
            1:       res = 1'b0;
            2:       res = 1'b1;
            3:       res = ~cur;
            default: res = cur;
        endcase
        return res;
    endfunction

    assign w_conf = en & s & r;
    assign w_any  = |w_conf;

    // Per-bit SR next-state; disabled bits hold.
    always_comb begin
        w_q_nxt = r_q;
        for (int i = 0; i < WIDTH; i++) begin
            if (en[i]) begin
                unique case ({s[i], r[i]})
                    2'b00: w_q_nxt[i] = r_q[i];
                    2'b01: w_q_nxt[i] = 1'b0;
                    2'b10: w_q_nxt[i] = 1'b1;
                    2'b11: w_q_nxt[i] = resolve(r_q[i]);
                endcase
            end
        end
    end

    // Status next-state: a new conflict beats a clear request.
    always_comb begin
        w_sticky_nxt = r_sticky;
        w_cnt_nxt    = r_cnt;
        if (w_any) begin
            w_sticky_nxt = 1'b1;
        end else if (clr_stat) begin
            w_sticky_nxt = 1'b0;
        end
        if (clr_stat) begin
            w_cnt_nxt = w_any ? CNT_ONE : '0;
        end else if (w_any && (r_cnt != CNT_MAX)) begin
            w_cnt_nxt = r_cnt + CNT_ONE;
        end
    end

    // State and complement registered together so they never agree.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_q        <= RESET_VAL;
            r_qbar     <= ~RESET_VAL;
            r_conflict <= '0;
            r_sticky   <= 1'b0;
            r_cnt      <= '0;
        end else begin
            r_q        <= w_q_nxt;
            r_qbar     <= ~w_q_nxt;
            r_conflict <= w_conf;
            r_sticky   <= w_sticky_nxt;
            r_cnt      <= w_cnt_nxt;
        end
    end

    assign q               = r_q;
    assign qbar            = r_qbar;
    assign conflict        = r_conflict;
    assign conflict_sticky = r_sticky;
    assign conflict_cnt    = r_cnt;

endmodule

// File: tb/tb_sr_ff_bank.sv
// tb_sr_ff_bank: four mode variants plus a 2-bit-counter variant,
// driven in lockstep and checked against a behavioural scoreboard.
module tb_sr_ff_bank;

    localparam int N = 5;

    logic       clk;
    logic       rst;
    logic [7:0] en;
    logic [7:0] s;
    logic [7:0] r;
    logic       clr;

    logic [7:0] q_o    [N];
    logic [7:0] qb_o   [N];
    logic [7:0] cf_o   [N];
    logic       st_o   [N];
    logic [7:0] cn_o   [4];
    logic [1:0] cn_sat;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [2:0] k;
        logic [7:0] q;
        logic [7:0] qb;
        logic [7:0] cf;
        logic       st;
        logic [7:0] cn;
    } exp_t;

    exp_t sb[$];

    logic [7:0] mq  [N];
    logic [7:0] mcf [N];
    logic       mst [N];
    logic [7:0] mcn [N];
    int mode_of [N] = '{0, 1, 2, 3, 0};
    int cmax    [N] = '{255, 255, 255, 255, 3};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar m = 0; m < 4; m++) begin : g_m
        sr_ff_bank #(
            .WIDTH(8), .CONFLICT_MODE(m),
            .RESET_VAL(8'hA5), .CNT_W(8)
        ) u_dut (
            .clk(clk), .rst(rst), .en(en), .s(s), .r(r),
            .clr_stat(clr),
            .q(q_o[m]), .qbar(qb_o[m]), .conflict(cf_o[m]),
            .conflict_sticky(st_o[m]), .conflict_cnt(cn_o[m])
        );
    end

    sr_ff_bank #(
        .WIDTH(8), .CONFLICT_MODE(0),
        .RESET_VAL(8'hA5), .CNT_W(2)
    ) u_sat (
        .clk(clk), .rst(rst), .en(en), .s(s), .r(r),
        .clr_stat(clr),
        .q(q_o[4]), .qbar(qb_o[4]), .conflict(cf_o[4]),
        .conflict_sticky(st_o[4]), .conflict_cnt(cn_sat)
    );

    function automatic logic [7:0] cnt_of(input int k);
        return (k == 4) ? {6'b0, cn_sat} : cn_o[k];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < N; k++) begin
            mq[k]  = 8'hA5;
            mcf[k] = 8'h00;
            mst[k] = 1'b0;
            mcn[k] = 8'h00;
        end
    endtask

    task automatic model_step(input int k);
        logic [7:0] c;
        logic       any;
        logic [7:0] nq;
        nq = mq[k];
        for (int i = 0; i < 8; i++) begin
            if (en[i]) begin
                if (s[i] && !r[i]) nq[i] = 1'b1;
                else if (!s[i] && r[i]) nq[i] = 1'b0;
                else if (s[i] && r[i]) begin
                    if (mode_of[k] == 1) nq[i] = 1'b0;
                    else if (mode_of[k] == 2) nq[i] = 1'b1;
                    else if (mode_of[k] == 3) nq[i] = ~mq[k][i];
                end
            end
        end
        c   = en & s & r;
        any = (c != 8'h00);
        if (clr) mcn[k] = any ? 8'd1 : 8'd0;
        else if (any && mcn[k] != cmax[k][7:0]) mcn[k] = mcn[k] + 8'd1;
        if (any) mst[k] = 1'b1;
        else if (clr) mst[k] = 1'b0;
        mq[k]  = nq;
        mcf[k] = c;
    endtask

    task automatic check_all(input string tag);
        exp_t x;
        while (sb.size() > 0) begin
            x = sb.pop_front();
            chk({tag, "_q"},  {24'b0, q_o[x.k]},  {24'b0, x.q});
            chk({tag, "_qb"}, {24'b0, qb_o[x.k]}, {24'b0, x.qb});
            chk({tag, "_cf"}, {24'b0, cf_o[x.k]}, {24'b0, x.cf});
            chk({tag, "_st"}, {31'b0, st_o[x.k]}, {31'b0, x.st});
            chk({tag, "_cn"}, {24'b0, cnt_of(x.k)}, {24'b0, x.cn});
        end
    endtask

    task automatic push_all();
        exp_t x;
        for (int k = 0; k < N; k++) begin
            x.k  = 3'(k);
            x.q  = mq[k];
            x.qb = ~mq[k];
            x.cf = mcf[k];
            x.st = mst[k];
            x.cn = mcn[k];
            sb.push_back(x);
        end
    endtask

    task automatic step(input string tag, input logic [7:0] e,
                        input logic [7:0] sv, input logic [7:0] rv,
                        input logic c);
        @(negedge clk);
        en  = e;
        s   = sv;
        r   = rv;
        clr = c;
        for (int k = 0; k < N; k++) model_step(k);
        push_all();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic async_reset(input string tag);
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        push_all();
        check_all(tag);
        @(negedge clk);
        en  = 8'h00;
        s   = 8'h00;
        r   = 8'h00;
        clr = 1'b0;
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b1;
        en  = 8'h00;
        s   = 8'h00;
        r   = 8'h00;
        clr = 1'b0;
        model_reset();

        async_reset("rst1");
        chk("rst1_q_a5",  {24'b0, q_o[0]},  32'hA5);
        chk("rst1_qb_5a", {24'b0, qb_o[0]}, 32'h5A);

        step("t2_clr", 8'hFF, 8'h00, 8'hFF, 1'b0);
        step("t2_set", 8'hFF, 8'h0F, 8'hF0, 1'b0);
        chk("t2_q_0f",  {24'b0, q_o[0]},  32'h0F);
        chk("t2_qb_f0", {24'b0, qb_o[0]}, 32'hF0);
        chk("t2_cf_00", {24'b0, cf_o[0]}, 32'h00);
        step("t2_hold", 8'hFF, 8'h00, 8'h00, 1'b0);
        chk("t2_hold_0f", {24'b0, q_o[0]}, 32'h0F);

        step("t3_prep", 8'hFF, 8'h01, 8'h00, 1'b1);
        for (int c = 0; c < 4; c++) begin
            step("t3_sr11", 8'h01, 8'h01, 8'h01, 1'b0);
            chk("t3_m0_q0", {31'b0, q_o[0][0]}, 32'd1);
            chk("t3_m1_q0", {31'b0, q_o[1][0]}, 32'd0);
            chk("t3_m2_q0", {31'b0, q_o[2][0]}, 32'd1);
            chk("t3_m3_q0", {31'b0, q_o[3][0]}, (c % 2 == 0) ? 32'd0 : 32'd1);
            chk("t3_cf0",   {31'b0, cf_o[3][0]}, 32'd1);
        end
        for (int k = 0; k < 4; k++) begin
            chk("t3_cnt4",  {24'b0, cnt_of(k)}, 32'd4);
            chk("t3_stick", {31'b0, st_o[k]},   32'd1);
        end

        step("t4_dis", 8'h00, 8'hFF, 8'hFF, 1'b0);
        chk("t4_cf",  {24'b0, cf_o[0]},  32'h00);
        chk("t4_cnt", {24'b0, cn_o[0]},  32'd4);
        chk("t4_q",   {24'b0, q_o[0]},   32'h0F);

        step("t5_clr", 8'h00, 8'h00, 8'h00, 1'b1);
        for (int c = 1; c <= 5; c++) begin
            step("t5_sat", 8'h01, 8'h01, 8'h01, 1'b0);
            chk("t5_cnt", {30'b0, cn_sat}, (c < 3) ? 32'(c) : 32'd3);
        end
        step("t5_clr_c", 8'h03, 8'h03, 8'h03, 1'b1);
        chk("t5_cc_cnt", {30'b0, cn_sat},  32'd1);
        chk("t5_cc_st",  {31'b0, st_o[4]}, 32'd1);
        step("t5_clr_n", 8'h00, 8'h00, 8'h00, 1'b1);
        chk("t5_cn_cnt", {30'b0, cn_sat},  32'd0);
        chk("t5_cn_st",  {31'b0, st_o[4]}, 32'd0);

        step("t6_act", 8'hFF, 8'hFF, 8'hFF, 1'b0);
        step("t6_act", 8'hFF, 8'hFF, 8'hFF, 1'b0);
        step("t6_act", 8'hFF, 8'h3C, 8'hFF, 1'b0);
        async_reset("rst2");
        chk("rst2_q3",  {24'b0, q_o[3]},  32'hA5);
        chk("rst2_cn3", {24'b0, cn_o[3]}, 32'd0);
        step("t6_first", 8'h01, 8'h01, 8'h00, 1'b0);
        chk("t6_q0",  {31'b0, q_o[2][0]}, 32'd1);
        chk("t6_cnt", {24'b0, cn_o[2]},   32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
